// File: rtl/ifetch_buf.sv
// rtl/ifetch_buf.sv - multi-cycle instruction fetch stage with prefetch FIFO and redirect
module ifetch_buf #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        Redirect,
  input  logic [31:0] newPC,
  input  logic        Ready,
  output logic        Valid,
  output logic [31:0] PC,
  output logic [31:0] nextPC,
  output logic [31:0] Ins
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t          state_q, state_d;
  logic            req_q, req_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     fpc_q, fpc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]     addr_mem [DEPTH];
  logic [31:0]     data_mem [DEPTH];
  logic            push, pop;

  always_comb begin
    pop      = (count_q != '0) && Ready && !Redirect;
    push     = (state_q == WAIT) && imem_ack && !Redirect;
    state_d  = state_q;
    req_d    = req_q;
    addr_d   = addr_q;
    fpc_d    = fpc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;

    if (Redirect) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      fpc_d    = newPC & 32'hFFFF_FFFC;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        fpc_d    = fpc_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
    end

    // Issue decisions look at next-cycle occupancy so a new request can follow an ack or pop directly.
    if (state_q != IDLE && !imem_ack) begin
      state_d = Redirect ? DROP : state_q;
      req_d   = 1'b1;
      addr_d  = addr_q;
    end else if (count_d < CW'(DEPTH)) begin
      state_d = WAIT;
      req_d   = 1'b1;
      addr_d  = fpc_d;
    end else begin
      state_d = IDLE;
      req_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
      fpc_q    <= RESET_PC;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      fpc_q    <= fpc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push && !RST) begin
      addr_mem[wr_ptr_q] <= addr_q;
      data_mem[wr_ptr_q] <= imem_rdata;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign Valid     = (count_q != '0);
  assign PC        = Valid ? addr_mem[rd_ptr_q] : 32'h0;
  assign Ins       = Valid ? data_mem[rd_ptr_q] : 32'h0;
  assign nextPC    = PC + 32'd4;

endmodule
